// File: rtl/nne_pkg.sv
// nne_pkg: shared definitions for the streaming CNN feature-map path.
// Holds the default sample width and channel count, the counter-width helper
// and the signed per-channel max used by the pooling stages.
package nne_pkg;

  // Default geometry of the packed feature-map bus.
  localparam int NNE_DATA_WIDHT = 32;
  localparam int NNE_CH         = 8;

  // Widest channel sample the max helper handles. Callers sign-extend their
  // samples to this width and truncate the result back.
  localparam int MAX_DW = 64;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Signed maximum of two sign-extended channel samples.
  function automatic logic signed [MAX_DW-1:0] smax(
    input logic signed [MAX_DW-1:0] a,
    input logic signed [MAX_DW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage : nne_pkg

// File: rtl/pool2x2_stage_if.sv
// pool2x2_stage_if: pixel stream into and pooled pixel stream out of the
// 2x2 max-pooling stage. The master side feeds pixels and receives pooled
// results; the slave side is the pooling stage itself.
interface pool2x2_stage_if import nne_pkg::*; #(
  parameter int DATA_WIDHT = NNE_DATA_WIDHT,
  parameter int CH         = NNE_CH
) ();

  logic                    Valid_In;
  logic [DATA_WIDHT*CH-1:0] Data_In;
  logic                    Valid_Out;
  logic [DATA_WIDHT*CH-1:0] Data_Out;
  logic                    Frame_End;

  modport master (
    output Valid_In,
    output Data_In,
    input  Valid_Out,
    input  Data_Out,
    input  Frame_End
  );

  modport slave (
    input  Valid_In,
    input  Data_In,
    output Valid_Out,
    output Data_Out,
    output Frame_End
  );

endinterface : pool2x2_stage_if

// File: rtl/pool_line_buf.sv
// pool_line_buf: one row of horizontally pooled pixels. Single synchronous
// write port, combinational read port. Contents are undefined after reset;
// the pooling stage rewrites every entry before reading it.
module pool_line_buf #(
  parameter int DEPTH = 23,
  parameter int WIDTH = 256,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one horizontal max per column pair while the even row streams in.
  // NOTE: no reset on the storage array -- a reset would force flops instead
  // of RAM, and every entry is written before it is ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : pool_line_buf

// File: rtl/pool2x2_stage.sv
// pool2x2_stage: 2x2, stride-2 signed max pooling on a raster pixel stream.
// Even rows fill a half-width line buffer with horizontal maxima; odd rows
// combine their horizontal maxima with it and emit one pooled pixel per
// column pair, one cycle after the bottom-right pixel of the window.
// Build option: define POOL_RELU_EN to clamp negative output channels to 0.
module pool2x2_stage import nne_pkg::*; #(
  parameter int DATA_WIDHT = NNE_DATA_WIDHT,
  parameter int CH         = NNE_CH,
  parameter int IMG_WIDTH  = 46,
  parameter int IMG_HEIGHT = 46
) (
  input  logic           clk,
  input  logic           rst,
  pool2x2_stage_if.slave bus
);

  localparam int PW       = DATA_WIDHT * CH;
  localparam int CW       = cnt_width(IMG_WIDTH);
  localparam int RW       = cnt_width(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int AW       = cnt_width(LB_DEPTH);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
  // Last column/row that belongs to a complete 2x2 window.
  localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * (IMG_WIDTH / 2) - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * (IMG_HEIGHT / 2) - 1);

  // Row parity is the phase: even rows fill the line buffer, odd rows emit.
  localparam logic [0:0] PH_FILL_LINE = 1'b0;
  localparam logic [0:0] PH_EMIT      = 1'b1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] left_q, left_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_end_q, frame_end_d;
  logic [PW-1:0] data_out_q, data_out_d;

  logic [0:0]    phase;
  logic          col_in_window;
  logic          row_in_window;
  logic          take_left;
  logic          pair_done;
  logic          emit;
  logic          lb_wr_en;
  logic [AW-1:0] lb_addr;
  logic [PW-1:0] lb_rd_data;
  logic [PW-1:0] hmax_row;
  logic [PW-1:0] pooled;
  logic [DATA_WIDHT-1:0] hmax_ch;
  logic [DATA_WIDHT-1:0] pool_ch;

  // Raster position: col wraps per row, row wraps at the true frame end.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.Valid_In) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Window bookkeeping: which pixels are kept, written or turned into output.
  // A trailing odd column or odd row is consumed without effect.
  always_comb begin
    phase         = row_q[0];
    col_in_window = (col_q <= COL_POOL_LAST);
    row_in_window = (row_q <= ROW_POOL_LAST);
    take_left     = bus.Valid_In && !col_q[0] && col_in_window;
    pair_done     = bus.Valid_In && col_q[0];
    lb_wr_en      = pair_done && (phase == PH_FILL_LINE) && row_in_window && !rst;
    emit          = pair_done && (phase == PH_EMIT);
    lb_addr       = AW'(col_q >> 1);
  end

  // Per-channel signed max tree: horizontal max against left_q, then
  // vertical max against the line-buffer entry for this column pair.
  always_comb begin
    hmax_row = '0;
    pooled   = '0;
    hmax_ch  = '0;
    pool_ch  = '0;
    for (int k = 0; k < CH; k++) begin
      hmax_ch = DATA_WIDHT'(smax(
        MAX_DW'(signed'(left_q[k*DATA_WIDHT +: DATA_WIDHT])),
        MAX_DW'(signed'(bus.Data_In[k*DATA_WIDHT +: DATA_WIDHT]))));
      pool_ch = DATA_WIDHT'(smax(
        MAX_DW'(signed'(hmax_ch)),
        MAX_DW'(signed'(lb_rd_data[k*DATA_WIDHT +: DATA_WIDHT]))));
`ifdef POOL_RELU_EN
      if (pool_ch[DATA_WIDHT-1]) begin
        pool_ch = '0;
      end
`endif
      hmax_row[k*DATA_WIDHT +: DATA_WIDHT] = hmax_ch;
      pooled[k*DATA_WIDHT +: DATA_WIDHT]   = pool_ch;
    end
  end

  // Next-state for the left pixel and the output registers.
  always_comb begin
    left_d      = take_left ? bus.Data_In : left_q;
    valid_out_d = emit;
    frame_end_d = emit && (row_q == ROW_POOL_LAST) && (col_q == COL_POOL_LAST);
    data_out_d  = emit ? pooled : data_out_q;
  end

  // State registers with synchronous reset; a pixel arriving with rst is dropped.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      left_q      <= '0;
      valid_out_q <= 1'b0;
      frame_end_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      left_q      <= left_d;
      valid_out_q <= valid_out_d;
      frame_end_q <= frame_end_d;
      data_out_q  <= data_out_d;
    end
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (hmax_row),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  assign bus.Valid_Out = valid_out_q;
  assign bus.Frame_End = frame_end_q;
  assign bus.Data_Out  = data_out_q;

endmodule : pool2x2_stage

// File: tb/tb_pool2x2_stage.sv
// tb_pool2x2_stage: directed, table-driven bench for pool2x2_stage.
// Two instances with CH=2, 32-bit samples: a 4x4 frame and a 5x5 frame.
// Expected outputs follow the POOL_RELU_EN setting of the build.
module tb_pool2x2_stage;

  localparam int DW = 32;
  localparam int CH = 2;
`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        vin;
    logic [31:0] c0;
    logic [31:0] c1;
    logic        ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        efe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_t tbl [64];
  int   n_vec   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pool2x2_stage_if #(.DATA_WIDHT(DW), .CH(CH)) if44 ();
  pool2x2_stage_if #(.DATA_WIDHT(DW), .CH(CH)) if55 ();

  pool2x2_stage #(
    .DATA_WIDHT(DW), .CH(CH), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) u_dut44 (
    .clk (clk),
    .rst (rst),
    .bus (if44.slave)
  );

  pool2x2_stage #(
    .DATA_WIDHT(DW), .CH(CH), .IMG_WIDTH(5), .IMG_HEIGHT(5)
  ) u_dut55 (
    .clk (clk),
    .rst (rst),
    .bus (if55.slave)
  );

  // Expected channel-1 value: negative maxima vanish when ReLU is built in.
  function automatic logic [31:0] x1(input int v);
    return (RELU && v < 0) ? 32'd0 : 32'(v);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [65:0] act, input logic [65:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {vout,fe,data}=%h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add_px(input logic v, input logic [31:0] c0, input logic [31:0] c1);
    vec_t r;
    r     = '0;
    r.vin = v;
    r.c0  = c0;
    r.c1  = c1;
    tbl[n_vec] = r;
    n_vec++;
  endtask

  task automatic expect_last(input logic [31:0] e0, input logic [31:0] e1, input logic efe);
    tbl[n_vec-1].ev  = 1'b1;
    tbl[n_vec-1].e0  = e0;
    tbl[n_vec-1].e1  = e1;
    tbl[n_vec-1].efe = efe;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [63:0] d);
    if44.Valid_In = (sel == 1'b0) ? v : 1'b0;
    if44.Data_In  = d;
    if55.Valid_In = (sel == 1'b1) ? v : 1'b0;
    if55.Data_In  = d;
  endtask

  // One cycle: drive on the falling edge, check 1 time unit after the rise.
  task automatic step(input bit sel, input vec_t r, input string name, input int idx);
    logic [65:0] act;
    logic [65:0] exp;
    @(negedge clk);
    rst = r.rst;
    drive(sel, r.vin, {r.c1, r.c0});
    @(posedge clk);
    #1;
    if (sel)
      act = {if55.Valid_Out, if55.Frame_End, if55.Valid_Out ? if55.Data_Out : 64'd0};
    else
      act = {if44.Valid_Out, if44.Frame_End, if44.Valid_Out ? if44.Data_Out : 64'd0};
    exp = {r.ev, r.efe, r.ev ? {r.e1, r.e0} : 64'd0};
    check(name, idx, act, exp);
  endtask

  task automatic run_table(input bit sel, input string name);
    for (int i = 0; i < n_vec; i++) step(sel, tbl[i], name, i);
    n_vec = 0;
  endtask

  // 4x4 ramp: ch0 = row*4+col, ch1 = -(row*4+col); optional idle gap after each pixel.
  task automatic build_ramp44(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      add_px(1'b1, 32'(i), 32'(-i));
      case (i)
        5:  expect_last(32'd5,  x1(0),   1'b0);
        7:  expect_last(32'd7,  x1(-2),  1'b0);
        13: expect_last(32'd13, x1(-8),  1'b0);
        15: expect_last(32'd15, x1(-10), 1'b1);
        default: ;
      endcase
      if (gaps) add_px(1'b0, 32'h0BAD_F00D, 32'h7FFF_FFFF);
    end
  endtask

  initial begin
    vec_t r;
    drive(1'b0, 1'b0, 64'd0);

    // Reset state, with a pixel presented during reset that must be dropped.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 64'h0000_0063_0000_0063);
    @(posedge clk);
    #1;
    check("reset44", 0, {if44.Valid_Out, if44.Frame_End, if44.Data_Out}, 66'd0);
    check("reset55", 0, {if55.Valid_Out, if55.Frame_End, if55.Data_Out}, 66'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    // Contiguous 4x4 ramp.
    build_ramp44(1'b0);
    run_table(1'b0, "ramp44");

    // Same frame with Valid_In every other cycle and junk data in the gaps.
    build_ramp44(1'b1);
    run_table(1'b0, "gap44");

    // Signed minimum in every channel must survive the max tree.
    for (int i = 0; i < 16; i++) begin
      add_px(1'b1, 32'h8000_0000, 32'h8000_0000);
      if (i == 5 || i == 7 || i == 13 || i == 15)
        expect_last(RELU ? 32'd0 : 32'h8000_0000, RELU ? 32'd0 : 32'h8000_0000, i == 15);
    end
    run_table(1'b0, "min44");

    // Two back-to-back 5x5 ramp frames; column 4 and row 4 are ignored.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 25; i++) begin
        add_px(1'b1, 32'(i), 32'(-i));
        case (i)
          6:  expect_last(32'd6,  x1(0),   1'b0);
          8:  expect_last(32'd8,  x1(-2),  1'b0);
          16: expect_last(32'd16, x1(-10), 1'b0);
          18: expect_last(32'd18, x1(-12), 1'b1);
          default: ;
        endcase
      end
    end
    run_table(1'b1, "ramp55");

    // Aborted frame: five pixels, a sixth arriving with rst, then a clean frame.
    for (int i = 0; i < 5; i++) begin
      r     = '0;
      r.vin = 1'b1;
      r.c0  = 32'(100 + i);
      r.c1  = 32'(200 + i);
      step(1'b0, r, "abort44", i);
    end
    r     = '0;
    r.rst = 1'b1;
    r.vin = 1'b1;
    r.c0  = 32'd105;
    r.c1  = 32'd205;
    step(1'b0, r, "abort44", 5);
    check("abort44_dout", 0, {2'b00, if44.Data_Out}, 66'd0);
    build_ramp44(1'b0);
    run_table(1'b0, "after_rst44");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pool2x2_stage
